// File: rtl/pl_stage_pmac_pkg.sv
// Shared constants and FSM encoding for the pointwise multiply-accumulate stage.
package pl_stage_pmac_pkg;

  localparam logic [13:0] NEWHOPE_Q = 14'd12289;
  localparam int          NEWHOPE_N = 512;
  localparam logic [14:0] BARRETT_M = 15'd21843;
  localparam int          BARRETT_K = 28;
  localparam int          PMAC_LAT  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pmac_state_e;

endpackage

// File: rtl/barrett_reduce_pl.sv
// Three-stage pipelined Barrett reduction of a 28-bit value modulo 12289.
// Stage order: quotient estimate, remainder, final conditional corrections.
module barrett_reduce_pl
  import pl_stage_pmac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        x_valid,
  input  logic [27:0] x,
  output logic        y_valid,
  output logic [13:0] y
);

  logic [42:0] prod;
  logic [14:0] t_d;
  logic        v1_q;
  logic [27:0] x1_q;
  logic [14:0] t1_q;
  logic [27:0] r_full;
  logic        v2_q;
  logic [15:0] r2_q;
  logic [15:0] y1;
  logic [15:0] y2;
  logic        unused_bits;

  assign prod   = 43'(x) * 43'(BARRETT_M);
  assign t_d    = prod[BARRETT_K +: 15];
  // The quotient estimate never overshoots, so the remainder stays below 3q.
  assign r_full = x1_q - 28'(t1_q) * 28'(NEWHOPE_Q);
  assign y1     = (r2_q >= 16'(NEWHOPE_Q)) ? r2_q - 16'(NEWHOPE_Q) : r2_q;
  assign y2     = (y1 >= 16'(NEWHOPE_Q)) ? y1 - 16'(NEWHOPE_Q) : y1;

  assign unused_bits = ^{prod[BARRETT_K-1:0], r_full[27:16], y2[15:14]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      x1_q    <= '0;
      t1_q    <= '0;
      v2_q    <= 1'b0;
      r2_q    <= '0;
      y_valid <= 1'b0;
      y       <= '0;
    end else if (en) begin
      v1_q    <= x_valid;
      x1_q    <= x;
      t1_q    <= t_d;
      v2_q    <= v1_q;
      r2_q    <= r_full[15:0];
      y_valid <= v2_q;
      y       <= y2[13:0];
    end
  end

endmodule

// File: rtl/pl_stage_pmac.sv
// Streams U[i] = (A[i]*S'[i] + E'[i]) mod q, one coefficient per cycle.
// POINTWISE_ADD_EN selects the E' accumulate path; undefined gives (A*S') mod q.
module pl_stage_pmac
  import pl_stage_pmac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start_stage,
  output logic        done_stage,
  output logic [8:0]  addr_a,
  input  logic [15:0] di_a,
  output logic [8:0]  addr_s,
  input  logic [15:0] di_s,
  output logic [8:0]  addr_e,
  input  logic [15:0] di_e,
  output logic        we_u,
  output logic [8:0]  addr_u,
  output logic [15:0] dout_u,
  output pmac_state_e state_dbg
);

  pmac_state_e state_q, state_d;
  logic [8:0]  cnt_q;
  logic        rd_v_q;
  logic        en_q;
  logic [13:0] hold_a, hold_s;
  logic [13:0] a_sel, s_sel, e_sel;
  logic        x_v_q;
  logic [27:0] x_q;
  logic        y_v;
  logic [13:0] y;
  logic [8:0]  wr_cnt_q;
  logic        cnt_last;
  logic        last_write;
  logic        unused_bits;

  assign cnt_last   = (cnt_q == 9'(NEWHOPE_N - 1));
  assign last_write = y_v && (wr_cnt_q == 9'(NEWHOPE_N - 1));

  always_comb begin
    state_d    = state_q;
    done_stage = 1'b0;
    case (state_q)
      IDLE:  if (start_stage) state_d = RUN;
      RUN:   if (cnt_last) state_d = DRAIN;
      DRAIN: if (last_write) state_d = DONE;
      DONE: begin
        done_stage = en;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_v_q   <= 1'b0;
      en_q     <= 1'b0;
      x_v_q    <= 1'b0;
      x_q      <= '0;
      wr_cnt_q <= '0;
    end else begin
      en_q <= en;
      if (en) begin
        state_q <= state_d;
        if (state_q == RUN) cnt_q <= cnt_q + 9'd1;
        rd_v_q <= (state_q == RUN);
        x_v_q  <= rd_v_q;
        x_q    <= 28'(a_sel) * 28'(s_sel) + 28'(e_sel);
        if (y_v) wr_cnt_q <= wr_cnt_q + 9'd1;
      end
    end
  end

  // RAM data for the address issued just before a stall only appears in the
  // first stalled cycle; keep a copy so it is not lost when en returns.
  always_ff @(posedge clk) begin
    if (en_q) begin
      hold_a <= di_a[13:0];
      hold_s <= di_s[13:0];
    end
  end

  assign a_sel = en_q ? di_a[13:0] : hold_a;
  assign s_sel = en_q ? di_s[13:0] : hold_s;

`ifdef POINTWISE_ADD_EN
  logic [13:0] hold_e;

  always_ff @(posedge clk) begin
    if (en_q) hold_e <= di_e[13:0];
  end

  assign e_sel       = en_q ? di_e[13:0] : hold_e;
  assign addr_e      = cnt_q;
  assign unused_bits = ^{di_a[15:14], di_s[15:14], di_e[15:14]};
`else
  assign e_sel       = 14'd0;
  assign addr_e      = 9'd0;
  assign unused_bits = ^{di_a[15:14], di_s[15:14], di_e};
`endif

  barrett_reduce_pl u_barrett (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .x_valid (x_v_q),
    .x       (x_q),
    .y_valid (y_v),
    .y       (y)
  );

  assign addr_a    = cnt_q;
  assign addr_s    = cnt_q;
  assign we_u      = y_v && en;
  assign addr_u    = wr_cnt_q;
  assign dout_u    = {2'b00, y};
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pl_stage_pmac.sv
// Directed bench for pl_stage_pmac: zero/one/max vectors, random model run,
// en stall with ignored start, and mid-run reset followed by a fresh run.
module tb_pl_stage_pmac;
  import pl_stage_pmac_pkg::*;

`ifdef POINTWISE_ADD_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, start_stage;
  logic        done_stage, we_u;
  logic [8:0]  addr_a, addr_s, addr_e, addr_u;
  logic [15:0] di_a, di_s, di_e, dout_u;
  pmac_state_e state_dbg;

  logic [15:0] mem_a [512];
  logic [15:0] mem_s [512];
  logic [15:0] mem_e [512];

  logic [15:0] exp_q [$];
  logic [15:0] got_data [$];
  logic [8:0]  got_addr [$];
  int          got_cyc [$];
  int          done_cyc [$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  pl_stage_pmac dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start_stage (start_stage),
    .done_stage  (done_stage),
    .addr_a      (addr_a),
    .di_a        (di_a),
    .addr_s      (addr_s),
    .di_s        (di_s),
    .addr_e      (addr_e),
    .di_e        (di_e),
    .we_u        (we_u),
    .addr_u      (addr_u),
    .dout_u      (dout_u),
    .state_dbg   (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read RAM models
  always @(posedge clk) begin
    di_a <= mem_a[addr_a];
    di_s <= mem_s[addr_s];
    di_e <= mem_e[addr_e];
  end

  // write/done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (we_u) begin
      got_data.push_back(dout_u);
      got_addr.push_back(addr_u);
      got_cyc.push_back(cyc);
    end
    if (done_stage) done_cyc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_addr.delete();
    got_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0: begin mem_a[i] = 16'd0; mem_s[i] = 16'd0; mem_e[i] = 16'd0; end
        1: begin mem_a[i] = 16'd1; mem_s[i] = 16'd1; mem_e[i] = 16'd1; end
        2: begin mem_a[i] = 16'd12288; mem_s[i] = 16'd12288; mem_e[i] = 16'd12288; end
        default: begin
          mem_a[i] = 16'($urandom_range(0, 12288));
          mem_s[i] = 16'($urandom_range(0, 12288));
          mem_e[i] = 16'($urandom_range(0, 12288));
        end
      endcase
    end
  endtask

  // Directed modes use hand-computed results; random mode uses a plain % model.
  task automatic build_exp(input int mode);
    longint p;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0: exp_q.push_back(16'd0);
        1: exp_q.push_back(ADD_EN ? 16'd2 : 16'd1);
        2: exp_q.push_back(ADD_EN ? 16'd0 : 16'd1);
        default: begin
          p = longint'(mem_a[i]) * longint'(mem_s[i]) + (ADD_EN ? longint'(mem_e[i]) : 64'd0);
          exp_q.push_back(16'(p % 12289));
        end
      endcase
    end
  endtask

  task automatic start(output int t);
    start_stage = 1'b1;
    t = cyc;
    step();
    start_stage = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
  endtask

  task automatic verify(input string name, input int t0, input int stall_at, input int stall_len);
    int n;
    int exp_c;
    logic [15:0] exp_d;
    check_eq({name, " n_writes"}, got_data.size(), 512);
    check_eq({name, " n_done"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check_eq({name, " done_cycle"}, done_cyc[0], t0 + 518 + stall_len);
    n = (got_data.size() < 512) ? got_data.size() : 512;
    for (int i = 0; i < n; i++) begin
      exp_c = t0 + 6 + i;
      if (stall_len > 0 && exp_c >= stall_at) exp_c += stall_len;
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check_eq($sformatf("%s data[%0d]", name, i), got_data[i], exp_d);
      check_eq($sformatf("%s addr[%0d]", name, i), got_addr[i], i);
      check_eq($sformatf("%s cyc[%0d]", name, i), got_cyc[i], exp_c);
    end
  endtask

  task automatic plain_run(input string name, input int mode);
    int t;
    fill_mem(mode);
    build_exp(mode);
    clear_mon();
    start(t);
    wait_done(700);
    verify(name, t, 0, 0);
  endtask

  initial begin
    int t;
    int t2;
    rst = 1'b1;
    en = 1'b1;
    start_stage = 1'b0;
    fill_mem(0);
    repeat (3) step();
    rst = 1'b0;

    check_eq("rst we_u", we_u, 0);
    check_eq("rst done", done_stage, 0);
    check_eq("rst addr_u", addr_u, 0);
    check_eq("rst dout_u", dout_u, 0);
    check_eq("rst addr_a", addr_a, 0);
    check_eq("rst addr_s", addr_s, 0);
    check_eq("rst addr_e", addr_e, 0);
    check_eq("rst state", 32'(state_dbg), 32'(IDLE));
    step();

    plain_run("zero", 0);
    plain_run("ones", 1);
    plain_run("max", 2);
    plain_run("rand", 3);

    // stall with a stray start mid-run
    fill_mem(3);
    build_exp(3);
    clear_mon();
    start(t);
    go_to(t + 50);
    start_stage = 1'b1;
    step();
    start_stage = 1'b0;
    go_to(t + 100);
    en = 1'b0;
    repeat (7) step();
    en = 1'b1;
    wait_done(700);
    verify("stall", t, t + 100, 7);

    // reset mid-run, then a fresh run
    fill_mem(3);
    clear_mon();
    start(t);
    go_to(t + 200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort we_u", we_u, 0);
    check_eq("abort addr_u", addr_u, 0);
    check_eq("abort addr_a", addr_a, 0);
    check_eq("abort state", 32'(state_dbg), 32'(IDLE));
    go_to(t + 209);
    check_eq("abort no_done", done_cyc.size(), 0);
    clear_mon();
    build_exp(3);
    go_to(t + 210);
    start(t2);
    wait_done(700);
    verify("rerun", t2, 0, 0);
    check_eq("rerun done_abs", (done_cyc.size() > 0) ? done_cyc[0] : 0, t + 728);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
